control_unit: RTL and testbench

//  Hardwired FSM sequencer that drives every load, tristate, register-bank and ALU-select line of datapath.

---
 rtl/control_unit_pkg.sv | 63 ++++++
 rtl/control_unit_decode.sv | 26 ++
 rtl/control_unit.sv | 162 ++++++++++++++++
 tb/tb_control_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit: FSM states, opcodes, ALU functions
// and the opcode-class bundle produced by the instruction decoder.
package control_unit_pkg;

  // PC advances by this constant each fetch (supplied by the datapath's constant-2 source)
  localparam int         PC_INC      = 2;
  localparam logic [4:0] RESET_STATE = 5'd0;

  // FSM state encodings
  localparam logic [4:0] S_IDLE = RESET_STATE;
  localparam logic [4:0] S_F0   = 5'd1;
  localparam logic [4:0] S_F1   = 5'd2;
  localparam logic [4:0] S_F2   = 5'd3;
  localparam logic [4:0] S_F3   = 5'd4;
  localparam logic [4:0] S_F4   = 5'd5;
  localparam logic [4:0] S_F5   = 5'd6;
  localparam logic [4:0] S_DEC  = 5'd7;
  localparam logic [4:0] S_E0   = 5'd8;
  localparam logic [4:0] S_E1   = 5'd9;
  localparam logic [4:0] S_E2   = 5'd10;
  localparam logic [4:0] S_L0   = 5'd11;
  localparam logic [4:0] S_L1   = 5'd12;
  localparam logic [4:0] S_L2   = 5'd13;
  localparam logic [4:0] S_L3   = 5'd14;
  localparam logic [4:0] S_L4   = 5'd15;
  localparam logic [4:0] S_W0   = 5'd16;
  localparam logic [4:0] S_W1   = 5'd17;
  localparam logic [4:0] S_W2   = 5'd18;
  localparam logic [4:0] S_W3   = 5'd19;
  localparam logic [4:0] S_W4   = 5'd20;
  localparam logic [4:0] S_B0   = 5'd21;
  localparam logic [4:0] S_B1   = 5'd22;
  localparam logic [4:0] S_HALT = 5'd23;

  // Opcodes outside the ALU range 0000-0110
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_BZ   = 4'b1010;
  localparam logic [3:0] OP_BN   = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU function selects; ALU opcodes use op[2:0] directly
  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_SUB   = 3'b001;
  localparam logic [2:0] FN_AND   = 3'b010;
  localparam logic [2:0] FN_OR    = 3'b011;
  localparam logic [2:0] FN_XOR   = 3'b100;
  localparam logic [2:0] FN_NOT   = 3'b101;
  localparam logic [2:0] FN_SHL   = 3'b110;
  localparam logic [2:0] FN_PASSX = 3'b111;

  typedef struct packed {
    logic is_alu;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_jmp;
    logic is_halt;
    logic is_ill;
  } op_class_t;

endpackage

// File: rtl/control_unit_decode.sv
// Opcode classifier: maps IR[15:12] to exactly one instruction class.
module control_unit_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] op,
  output op_class_t  cls
);

  // One-hot class from opcode; 0111, 1101 and 1110 fall through to illegal
  always_comb begin
    cls = '0;
    if (!op[3] && (op[2:0] != 3'b111)) begin
      cls.is_alu = 1'b1;
    end else begin
      case (op)
        OP_LD:        cls.is_ld   = 1'b1;
        OP_ST:        cls.is_st   = 1'b1;
        OP_BZ, OP_BN: cls.is_br   = 1'b1;
        OP_JMP:       cls.is_jmp  = 1'b1;
        OP_HALT:      cls.is_halt = 1'b1;
        default:      cls.is_ill  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 16-bit datapath.
// Moore machine: every control line is a function of the state and the
// IR fields latched in DEC; IDLE and HALT drive all control lines low.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        zin,
  input  logic        sin,
  input  logic        cin,
  input  logic        vin,
  input  logic        mem_rdy,
  output logic        lmar,
  output logic        lt,
  output logic        lpc,
  output logic        lir,
  output logic        lmdr,
  output logic        ldx,
  output logic        ldy,
  output logic        tt,
  output logic        tpc,
  output logic        tp,
  output logic        t2,
  output logic        tmdr2x,
  output logic        rmdri,
  output logic        rmarx,
  output logic        rdr,
  output logic        wrr,
  output logic [2:0]  pa,
  output logic [2:0]  wpa,
  output logic [2:0]  fnsel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal
);

  logic [4:0] state;
  logic [4:0] state_nx;
  logic [2:0] rd_f;
  logic [2:0] rs_f;
  logic [2:0] fn_f;
  logic [3:0] flags;      // {z, s, c, v} from the last ALU writeback
  op_class_t  cls;
  logic       br_taken;
  logic       unused_bits;

  control_unit_decode u_decode (
    .op  (ir[15:12]),
    .cls (cls)
  );

  // JMP always redirects; BZ (op[0]=0) tests z, BN (op[0]=1) tests s
  assign br_taken    = cls.is_jmp || (cls.is_br && (ir[12] ? flags[2] : flags[3]));
  assign unused_bits = ^{ir[5:0], flags[1:0]};

  // Next-state sequencing; memory states hold until mem_rdy
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_F0;
      S_F0:   state_nx = S_F1;
      S_F1:   state_nx = S_F2;
      S_F2:   if (mem_rdy) state_nx = S_F3;
      S_F3:   state_nx = S_F4;
      S_F4:   state_nx = S_F5;
      S_F5:   state_nx = S_DEC;
      S_DEC: begin
        if (cls.is_alu)     state_nx = S_E0;
        else if (cls.is_ld) state_nx = S_L0;
        else if (cls.is_st) state_nx = S_W0;
        else if (br_taken)  state_nx = S_B0;
        else if (cls.is_br) state_nx = S_F0;
        else                state_nx = S_HALT;
      end
      S_E0:   state_nx = S_E1;
      S_E1:   state_nx = S_E2;
      S_E2:   state_nx = S_F0;
      S_L0:   state_nx = S_L1;
      S_L1:   state_nx = S_L2;
      S_L2:   if (mem_rdy) state_nx = S_L3;
      S_L3:   state_nx = S_L4;
      S_L4:   state_nx = S_F0;
      S_W0:   state_nx = S_W1;
      S_W1:   state_nx = S_W2;
      S_W2:   state_nx = S_W3;
      S_W3:   state_nx = S_W4;
      S_W4:   if (mem_rdy) state_nx = S_F0;
      S_B0:   state_nx = S_B1;
      S_B1:   state_nx = S_F0;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Latch register addresses and ALU function while decoding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_f <= '0;
      rs_f <= '0;
      fn_f <= '0;
    end else if (state == S_DEC) begin
      rd_f <= ir[11:9];
      rs_f <= ir[8:6];
      fn_f <= ir[14:12];
    end
  end

  // Flags follow only ALU-op writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                flags <= '0;
    else if (state == S_E2)  flags <= {zin, sin, cin, vin};
  end

  // Sticky halt status, set as DEC commits to HALT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else if (state == S_DEC) begin
      if (cls.is_halt || cls.is_ill) halted  <= 1'b1;
      if (cls.is_ill)                illegal <= 1'b1;
    end
  end

  // Control word decode; memory requests appear only once MAR holds the address
  always_comb begin
    lmar = 1'b0; lt = 1'b0; lpc = 1'b0; lir = 1'b0; lmdr = 1'b0; ldx = 1'b0; ldy = 1'b0;
    tt = 1'b0; tpc = 1'b0; tp = 1'b0; t2 = 1'b0; tmdr2x = 1'b0;
    rmdri = 1'b0; rmarx = 1'b0; rdr = 1'b0; wrr = 1'b0;
    pa = 3'b000; wpa = 3'b000; fnsel = 3'b000;
    mem_rd = 1'b0; mem_wr = 1'b0;
    case (state)
      S_F0, S_F3:       begin tpc = 1'b1; ldx = 1'b1; end
      S_F1, S_L1, S_W1: begin fnsel = FN_PASSX; lmar = 1'b1; end
      S_F2:             begin mem_rd = 1'b1; rmarx = 1'b1; lmdr = 1'b1; lir = 1'b1; end
      S_F4:             begin t2 = 1'b1; ldy = 1'b1; end
      S_F5:             begin fnsel = FN_ADD; lpc = 1'b1; end
      S_E0:             begin rdr = 1'b1; pa = rs_f; tp = 1'b1; ldy = 1'b1; end
      S_E1, S_W2:       begin rdr = 1'b1; pa = rd_f; tp = 1'b1; ldx = 1'b1; end
      S_E2:             begin fnsel = fn_f; wrr = 1'b1; wpa = rd_f; end
      S_L0, S_W0, S_B0: begin rdr = 1'b1; pa = rs_f; tp = 1'b1; ldx = 1'b1; end
      S_L2:             begin mem_rd = 1'b1; rmarx = 1'b1; lmdr = 1'b1; end
      S_L3:             begin tmdr2x = 1'b1; ldx = 1'b1; end
      S_L4:             begin fnsel = FN_PASSX; wrr = 1'b1; wpa = rd_f; end
      S_W3:             begin fnsel = FN_PASSX; rmdri = 1'b1; lmdr = 1'b1; end
      S_W4:             begin mem_wr = 1'b1; end
      S_B1:             begin fnsel = FN_PASSX; lpc = 1'b1; end
      default:          begin end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed programs push expected
// register-write / PC-load / memory-burst / halt events; a monitor pops and
// compares them as the DUT produces them, and checks bus exclusivity each cycle.
`timescale 1ns/1ps
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        zin = 1'b0, sin = 1'b0, cin = 1'b0, vin = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        lmar, lt, lpc, lir, lmdr, ldx, ldy;
  logic        tt, tpc, tp, t2, tmdr2x;
  logic        rmdri, rmarx, rdr, wrr;
  logic [2:0]  pa, wpa, fnsel;
  logic        mem_rd, mem_wr, halted, illegal;

  control_unit dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir),
    .zin(zin), .sin(sin), .cin(cin), .vin(vin), .mem_rdy(mem_rdy),
    .lmar(lmar), .lt(lt), .lpc(lpc), .lir(lir), .lmdr(lmdr), .ldx(ldx), .ldy(ldy),
    .tt(tt), .tpc(tpc), .tp(tp), .t2(t2), .tmdr2x(tmdr2x),
    .rmdri(rmdri), .rmarx(rmarx), .rdr(rdr), .wrr(wrr),
    .pa(pa), .wpa(wpa), .fnsel(fnsel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] K_RD = 4'd1, K_WR = 4'd2, K_WRR = 4'd3, K_LPC = 4'd4, K_HALT = 4'd5;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] cyc;
    logic [15:0] val;
  } ev_t;

  typedef struct {
    logic [15:0] word;
    logic        z;
  } instr_t;

  ev_t         exp_q[$];
  instr_t      prog[$];
  instr_t      cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cyc = 0;
  logic [31:0] base = 0;
  int          fetch_lat = 0, rd_lat = 0, wr_lat = 0, lat = 0, waited = 0;
  int          rd_len = 0, wr_len = 0;
  logic [31:0] rd_st = 0, wr_st = 0;
  logic        prev_h = 1'b0;
  logic        found;
  logic [26:0] cw;
  logic [4:0]  bus;

  assign cw  = {lmar, lt, lpc, lir, lmdr, ldx, ldy, tt, tpc, tp, t2, tmdr2x,
                rmdri, rmarx, rdr, wrr, pa, wpa, fnsel, mem_rd, mem_wr};
  assign bus = {tt, tpc, tp, t2, tmdr2x};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report(input logic [3:0] k, input logic [31:0] c, input logic [15:0] v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind %0d at cycle +%0d value %0h, none expected", k, c - base, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.cyc !== c || e.val !== v) begin
        n_bad++;
        $display("FAIL event: got kind %0d cycle +%0d value %0h, expected kind %0d cycle +%0d value %0h",
                 k, c - base, v, e.kind, e.cyc - base, e.val);
      end
    end
  endtask

  // Monitor: per-cycle bus rules plus event extraction
  always @(negedge clk) begin
    if (!rst) begin
      rd_len = 0;
      wr_len = 0;
      prev_h = 1'b0;
    end else begin
      check("bus_one_driver", 32'($countones(bus) <= 1), 32'd1);
      check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (mem_rd) begin
        if (rd_len == 0) rd_st = cyc;
        rd_len++;
      end else if (rd_len != 0) begin
        report(K_RD, rd_st, 16'(rd_len));
        rd_len = 0;
      end
      if (mem_wr) begin
        if (wr_len == 0) wr_st = cyc;
        wr_len++;
      end else if (wr_len != 0) begin
        report(K_WR, wr_st, 16'(wr_len));
        wr_len = 0;
      end
      if (wrr) report(K_WRR, cyc, {10'd0, wpa, fnsel});
      if (lpc) report(K_LPC, cyc, {13'd0, fnsel});
      if (halted && !prev_h) report(K_HALT, cyc, {15'd0, illegal});
      prev_h = halted;
    end
  end

  // Memory / IR responder: grants after a programmable wait, loads next instruction on fetch
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      lat = lir ? fetch_lat : (mem_rd ? rd_lat : wr_lat);
      if (waited >= lat) begin
        mem_rdy = 1'b1;
        waited  = 0;
        if (lir) begin
          if (prog.size() > 0) begin
            cur = prog.pop_front();
            ir  = cur.word;
            zin = cur.z;
          end else begin
            ir  = 16'hF000;
          end
        end
      end else begin
        mem_rdy = 1'b0;
        waited++;
      end
    end else begin
      mem_rdy = 1'b0;
      waited  = 0;
    end
  end

  task automatic add(input logic [15:0] w, input logic z);
    instr_t i;
    i.word = w;
    i.z    = z;
    prog.push_back(i);
  endtask

  task automatic ev(input logic [3:0] k, input int off, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = base + 32'(off);
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    base  = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    exp_q.delete();
    prog.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(cw), 32'd0);
    check("reset_status", {30'd0, halted, illegal}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_phase(input logic exp_ill);
    for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
    check("halt_reached", {31'd0, halted}, 32'd1);
    repeat (2) @(negedge clk);
    check("pending_events", 32'(exp_q.size()), 32'd0);
    check("illegal_flag", {31'd0, illegal}, {31'd0, exp_ill});
    check("halt_outputs_zero", 32'(cw), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("halt_sticky", {30'd0, halted, illegal}, {30'd0, 1'b1, exp_ill});
    check("halt_ignores_start", 32'(cw), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("por_outputs", 32'(cw), 32'd0);
    check("por_status", {30'd0, halted, illegal}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_waits_for_start", 32'(cw), 32'd0);

    // Reset asserted while F2 waits with mem_rd high
    fetch_lat = 10;
    add(16'h0250, 1'b0);
    go();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_rd) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("f2_mem_rd_high", {31'd0, found}, 32'd1);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("async_reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    check("reset_mid_f2_outputs", 32'(cw), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_mid_reset", 32'(cw), 32'd0);
    prog.delete();
    fetch_lat = 0;

    // ADD r1,r1,r1 then HALT, with a stray start mid-instruction
    add(16'h0250, 1'b0);
    add(16'hF000, 1'b0);
    go();
    ev(K_RD, 2, 16'd1);   ev(K_LPC, 5, 16'd0);  ev(K_WRR, 9, 16'h08);
    ev(K_RD, 12, 16'd1);  ev(K_LPC, 15, 16'd0); ev(K_HALT, 17, 16'd0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_phase(1'b0);

    // SUB sets z; BZ taken twice; ADD clears z; BZ not taken; HALT
    do_reset();
    add(16'h14C0, 1'b1);
    add(16'hA140, 1'b0);
    add(16'hA140, 1'b0);
    add(16'h0250, 1'b0);
    add(16'hA140, 1'b0);
    add(16'hF000, 1'b0);
    go();
    ev(K_RD, 2, 16'd1);   ev(K_LPC, 5, 16'd0);  ev(K_WRR, 9, 16'h11);
    ev(K_RD, 12, 16'd1);  ev(K_LPC, 15, 16'd0); ev(K_LPC, 18, 16'd7);
    ev(K_RD, 21, 16'd1);  ev(K_LPC, 24, 16'd0); ev(K_LPC, 27, 16'd7);
    ev(K_RD, 30, 16'd1);  ev(K_LPC, 33, 16'd0); ev(K_WRR, 37, 16'h08);
    ev(K_RD, 40, 16'd1);  ev(K_LPC, 43, 16'd0);
    ev(K_RD, 47, 16'd1);  ev(K_LPC, 50, 16'd0); ev(K_HALT, 52, 16'd0);
    finish_phase(1'b0);

    // LD r2,[r3] (3-cycle wait), ST r4,[r5] (2-cycle wait), JMP r6, illegal 0xD000
    do_reset();
    rd_lat = 3;
    wr_lat = 2;
    add(16'h84C0, 1'b0);
    add(16'h9940, 1'b0);
    add(16'hC180, 1'b0);
    add(16'hD000, 1'b0);
    go();
    ev(K_RD, 2, 16'd1);   ev(K_LPC, 5, 16'd0);  ev(K_RD, 9, 16'd4);  ev(K_WRR, 14, 16'h17);
    ev(K_RD, 17, 16'd1);  ev(K_LPC, 20, 16'd0); ev(K_WR, 26, 16'd3);
    ev(K_RD, 31, 16'd1);  ev(K_LPC, 34, 16'd0); ev(K_LPC, 37, 16'd7);
    ev(K_RD, 40, 16'd1);  ev(K_LPC, 43, 16'd0); ev(K_HALT, 45, 16'd1);
    finish_phase(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
